// File: rtl/cmp_sar_reader.sv
// Successive-approximation reader for an external a>b comparator.
// Drives thresholds onto the comparator's B input and rebuilds the hidden
// A operand from the 1-bit greater-than answers, MSB first. An optional
// final probe checks the result against the comparator to flag
// non-monotone (approximate) comparator answers.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. start_ready is high only in IDLE, so the start transfer
// is start_valid & start_ready. out_valid, out_value and mono_err stay
// constant from the first DONE cycle until the out_valid & out_ready edge.
module cmp_sar_reader #(
  parameter int W       = 3,
  parameter int CMP_LAT = 0,
  parameter int VERIFY  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  output logic [W-1:0] cmp_b,
  output logic         cmp_req,
  input  logic         cmp_gt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_value,
  output logic         mono_err,
  output logic [1:0]   dbg_state
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int LW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_n;
  logic [W-1:0]   res_q, res_n;
  logic [W-1:0]   cmp_b_q, cmp_b_n;
  logic [BW-1:0]  bit_q, bit_n;
  logic [LW-1:0]  wcnt_q, wcnt_n;
  logic           err_q, err_n;

  logic [W-1:0]   one;
  logic [W-1:0]   trial;
  logic [W-1:0]   res_sel;
  logic [W-1:0]   next_trial;
  logic           settled;

  // Trial arithmetic for the bit under test; next_trial is only used when bit_q > 0.
  always_comb begin
    one        = W'(1);
    trial      = res_q | (one << bit_q);
    res_sel    = cmp_gt ? trial : res_q;
    next_trial = res_sel | (one << (bit_q - BW'(1)));
    settled    = (int'(wcnt_q) >= CMP_LAT);
  end

  // Next-state and datapath updates; every probe waits CMP_LAT cycles before sampling.
  always_comb begin
    state_n = state_q;
    res_n   = res_q;
    cmp_b_n = cmp_b_q;
    bit_n   = bit_q;
    wcnt_n  = wcnt_q;
    err_n   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          res_n   = '0;
          bit_n   = BW'(W - 1);
          cmp_b_n = (one << (W - 1)) - one;
          wcnt_n  = '0;
          err_n   = 1'b0;
          state_n = S_PROBE;
        end
      end
      S_PROBE: begin
        if (!settled) begin
          wcnt_n = wcnt_q + LW'(1);
        end else begin
          res_n  = res_sel;
          wcnt_n = '0;
          if (bit_q != '0) begin
            bit_n   = bit_q - BW'(1);
            cmp_b_n = next_trial - one;
          end else if (VERIFY != 0) begin
            cmp_b_n = res_sel;
            state_n = S_VERIFY;
          end else begin
            cmp_b_n = '0;
            state_n = S_DONE;
          end
        end
      end
      S_VERIFY: begin
        if (!settled) begin
          wcnt_n = wcnt_q + LW'(1);
        end else begin
          // A > res contradicts the answers that produced res.
          err_n   = cmp_gt;
          cmp_b_n = '0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cmp_b_q <= '0;
      bit_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      res_q   <= res_n;
      cmp_b_q <= cmp_b_n;
      bit_q   <= bit_n;
      wcnt_q  <= wcnt_n;
      err_q   <= err_n;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    start_ready = (state_q == S_IDLE);
    cmp_req     = (state_q == S_PROBE) || (state_q == S_VERIFY);
    out_valid   = (state_q == S_DONE);
    cmp_b       = cmp_b_q;
    out_value   = res_q;
    mono_err    = err_q;
    dbg_state   = state_q;
  end

endmodule
